// File: rtl/fp_pkg.sv
// Shared floating-point definitions used by the multiply path
// (multiplier, controller and normalizer).
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Exponent field width grows by three bits per doubling of the word size.
    function automatic int exp_width(input int size);
        return 5 + ($clog2(size) - 4) * 3;
    endfunction

    // Standard IEEE-style exponent bias for a given exponent width.
    function automatic int exp_bias(input int expw);
        return (2 ** (expw - 1)) - 1;
    endfunction

endpackage

// File: rtl/unpack_fp.sv
// Splits a packed {sign, exponent, fraction} operand into its sign, the
// effective exponent (subnormals read as 1) and the significand with the
// hidden bit restored.
module unpack_fp #(
    parameter int SIZE     = 64,
    parameter int EXPONENT = 11,
    parameter int FRACTION = 52
) (
    input  logic [SIZE-1:0]     i_op,
    output logic                o_sign,
    output logic [EXPONENT-1:0] o_exp,
    output logic [FRACTION:0]   o_sig
);

    logic [EXPONENT-1:0] expField;
    logic [FRACTION-1:0] fracField;
    logic                hidden;

    assign o_sign    = i_op[SIZE-1];
    assign expField  = i_op[SIZE-2 -: EXPONENT];
    assign fracField = i_op[FRACTION-1:0];
    assign hidden    = |expField;
    assign o_exp     = hidden ? expField : EXPONENT'(1);
    assign o_sig     = {hidden, fracField};

endmodule

// File: rtl/mult_mantissa_fp.sv
// Iterative shift-add significand multiplier. A load captures both
// significands, the result sign and the biased exponent sum. Each enabled
// cycle then retires one multiplier bit, so the full double-width product is
// ready FRACTION+1 enabled cycles after the load.
module mult_mantissa_fp
    import fp_pkg::*;
#(
    parameter int SIZE     = 64,
    parameter int EXPONENT = exp_width(SIZE),
    parameter int FRACTION = SIZE - EXPONENT - 1,
    parameter int BIAS     = exp_bias(EXPONENT)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic                          i_clr_n,
    input  logic [SIZE-1:0]               i_a,
    input  logic [SIZE-1:0]               i_b,
    output logic                          o_sign,
    output logic signed [EXPONENT+1:0]    o_exp,
    output logic [2*(FRACTION+1)-1:0]     o_mant,
    output logic                          o_done
);

    localparam int SIG_W  = FRACTION + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int EXP_W  = EXPONENT + 2;
    localparam int CNT_W  = $clog2(FRACTION + 2);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(FRACTION);

    logic                signA, signB;
    logic [EXPONENT-1:0] effExpA, effExpB;
    logic [SIG_W-1:0]    sigA, sigB;

    state_t              state_q, state_d;
    logic [SIG_W-1:0]    mcand_q, mcand_d;
    logic [SIG_W-1:0]    mplier_q, mplier_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sign_q, sign_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic                done_q, done_d;

    logic [EXP_W-1:0]    loadExp;
    logic [PROD_W-1:0]   partial;

    unpack_fp #(.SIZE(SIZE), .EXPONENT(EXPONENT), .FRACTION(FRACTION)) u_unpack_a (
        .i_op   (i_a),
        .o_sign (signA),
        .o_exp  (effExpA),
        .o_sig  (sigA)
    );

    unpack_fp #(.SIZE(SIZE), .EXPONENT(EXPONENT), .FRACTION(FRACTION)) u_unpack_b (
        .i_op   (i_b),
        .o_sign (signB),
        .o_exp  (effExpB),
        .o_sig  (sigB)
    );

    // Exponent sum wraps in EXP_W bits; range handling belongs downstream.
    assign loadExp = {2'b00, effExpA} + {2'b00, effExpB} - EXP_W'(BIAS);
    assign partial = {{SIG_W{1'b0}}, mcand_q} << cnt_q;

    // Next-state logic: a load always wins, otherwise BUSY retires one bit per enabled cycle.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        done_d   = done_q;
        if (!i_clr_n) begin
            mcand_d  = sigA;
            mplier_d = sigB;
            acc_d    = '0;
            cnt_d    = '0;
            sign_d   = signA ^ signB;
            exp_d    = loadExp;
            done_d   = 1'b0;
            state_d  = BUSY;
        end else begin
            case (state_q)
                BUSY: begin
                    if (i_en) begin
                        if (mplier_q[0]) begin
                            acc_d = acc_q + partial;
                        end
                        mplier_d = mplier_q >> 1;
                        cnt_d    = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_ITER) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and datapath registers; reset abandons any partial product.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            done_q   <= done_d;
        end
    end

    assign o_sign = sign_q;
    assign o_exp  = exp_q;
    assign o_mant = acc_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_mult_mantissa_fp.sv
// Self-checking bench for mult_mantissa_fp at SIZE=16 (EXPONENT=5,
// FRACTION=10, BIAS=15). Expected values come from integer arithmetic on the
// unpacked operand fields.
module tb_mult_mantissa_fp;

    localparam int SIZE  = 16;
    localparam int ITERS = 11;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_en = 1'b0;
    logic        i_clr_n = 1'b1;
    logic [15:0] i_a = '0;
    logic [15:0] i_b = '0;
    logic        o_sign;
    logic signed [6:0] o_exp;
    logic [21:0] o_mant;
    logic        o_done;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    mult_mantissa_fp #(.SIZE(SIZE)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_clr_n (i_clr_n),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_sign  (o_sign),
        .o_exp   (o_exp),
        .o_mant  (o_mant),
        .o_done  (o_done)
    );

    always #5 i_clk = ~i_clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference model from the number format: value fields as integers.
    function automatic int sigOf(input logic [15:0] x);
        int e = int'(x[14:10]);
        int f = int'(x[9:0]);
        return (e != 0) ? (1024 + f) : f;
    endfunction

    function automatic int effExpOf(input logic [15:0] x);
        int e = int'(x[14:10]);
        return (e != 0) ? e : 1;
    endfunction

    // Load both operands (i_en also high to prove the load has priority).
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
        i_a = a;
        i_b = b;
        i_clr_n = 1'b0;
        i_en = 1'b1;
        tick();
        i_clr_n = 1'b1;
        i_en = 1'b0;
        i_a = 16'($urandom);
        i_b = 16'($urandom);
    endtask

    // Directed operation with an optional enable pause after pauseAfter iterations.
    task automatic runOp(input logic [15:0] a, input logic [15:0] b,
                         input int pauseAfter, input int pauseLen, input string tag);
        logic [31:0] expSign, expExp, expMant;
        int e;
        expSign = {31'b0, a[15] ^ b[15]};
        e = effExpOf(a) + effExpOf(b) - 15;
        expExp  = {25'b0, 7'(e)};
        expMant = 32'(sigOf(a) * sigOf(b));
        applyStimulus(a, b);
        checkOutput({tag, ".sign"}, {31'b0, o_sign}, expSign);
        checkOutput({tag, ".exp"}, {25'b0, o_exp}, expExp);
        checkOutput({tag, ".doneAfterLoad"}, {31'b0, o_done}, 32'd0);
        for (int k = 0; k < ITERS; k++) begin
            if (k == pauseAfter) begin
                i_en = 1'b0;
                repeat (pauseLen) tick();
                checkOutput({tag, ".doneInPause"}, {31'b0, o_done}, 32'd0);
            end
            if (k == ITERS - 1) begin
                checkOutput({tag, ".doneBeforeLast"}, {31'b0, o_done}, 32'd0);
            end
            i_en = 1'b1;
            tick();
        end
        i_en = 1'b0;
        checkOutput({tag, ".done"}, {31'b0, o_done}, 32'd1);
        checkOutput({tag, ".mant"}, {10'b0, o_mant}, expMant);
        checkOutput({tag, ".signHold"}, {31'b0, o_sign}, expSign);
        checkOutput({tag, ".expHold"}, {25'b0, o_exp}, expExp);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [31:0] savedMant;
        int edges, cyc, e;

        // Reset and idle behaviour.
        i_rst = 1'b1;
        repeat (2) tick();
        i_rst = 1'b0;
        tick();
        checkOutput("reset.sign", {31'b0, o_sign}, 32'd0);
        checkOutput("reset.exp", {25'b0, o_exp}, 32'd0);
        checkOutput("reset.mant", {10'b0, o_mant}, 32'd0);
        checkOutput("reset.done", {31'b0, o_done}, 32'd0);
        i_a = 16'h3E00;
        i_b = 16'h4000;
        repeat (3) tick();
        checkOutput("idleNoEn.mant", {10'b0, o_mant}, 32'd0);
        i_en = 1'b1;
        repeat (15) tick();
        i_en = 1'b0;
        checkOutput("idleEn.done", {31'b0, o_done}, 32'd0);
        checkOutput("idleEn.exp", {25'b0, o_exp}, 32'd0);

        // Directed cases with literal expectations.
        runOp(16'h3E00, 16'h4000, -1, 0, "1p5x2");
        checkOutput("1p5x2.lit.exp", {25'b0, o_exp}, 32'h10);
        checkOutput("1p5x2.lit.mant", {10'b0, o_mant}, 32'h180000);

        // DONE holds with enable toggling, then a new load drops done on its edge.
        savedMant = {10'b0, o_mant};
        i_en = 1'b1;
        repeat (4) tick();
        i_en = 1'b0;
        checkOutput("doneHold.done", {31'b0, o_done}, 32'd1);
        checkOutput("doneHold.mant", {10'b0, o_mant}, savedMant);

        runOp(16'hBC00, 16'h3C00, -1, 0, "neg1x1");
        checkOutput("neg1x1.lit.sign", {31'b0, o_sign}, 32'd1);
        checkOutput("neg1x1.lit.exp", {25'b0, o_exp}, 32'd15);
        checkOutput("neg1x1.lit.mant", {10'b0, o_mant}, 32'h100000);

        runOp(16'h0400, 16'h0400, -1, 0, "minNorm");
        checkOutput("minNorm.lit.exp", {25'b0, o_exp}, 32'h73);
        checkOutput("minNorm.lit.mant", {10'b0, o_mant}, 32'h100000);

        runOp(16'h0001, 16'h3C00, -1, 0, "subnorm");
        checkOutput("subnorm.lit.exp", {25'b0, o_exp}, 32'd1);
        checkOutput("subnorm.lit.mant", {10'b0, o_mant}, 32'h000400);

        runOp(16'h0000, 16'h7BFF, -1, 0, "zero");

        // Enable pause of 3 cycles mid-BUSY.
        runOp(16'h3E00, 16'h4000, 5, 3, "pause");
        checkOutput("pause.lit.mant", {10'b0, o_mant}, 32'h180000);

        // Reset mid-iteration clears outputs without waiting for an edge.
        applyStimulus(16'hBFFF, 16'hBFFF);
        i_en = 1'b1;
        repeat (5) tick();
        i_en = 1'b0;
        checkOutput("midRst.partialNonZero", {31'b0, (o_mant != 22'd0)}, 32'd1);
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        checkOutput("midRst.sign", {31'b0, o_sign}, 32'd0);
        checkOutput("midRst.exp", {25'b0, o_exp}, 32'd0);
        checkOutput("midRst.mant", {10'b0, o_mant}, 32'd0);
        checkOutput("midRst.done", {31'b0, o_done}, 32'd0);
        tick();
        i_rst = 1'b0;
        tick();

        // Random operands with random enable gating, bounded in cycles.
        for (int n = 0; n < 20; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            applyStimulus(ra, rb);
            edges = 0;
            cyc = 0;
            while (edges < ITERS && cyc < 200) begin
                i_en = 1'($urandom_range(0, 1));
                if (i_en) edges++;
                tick();
                cyc++;
                if (edges < ITERS) begin
                    checkOutput("rand.doneEarly", {31'b0, o_done}, 32'd0);
                end
            end
            i_en = 1'b0;
            checkOutput("rand.enabledEdges", 32'(edges), 32'(ITERS));
            e = effExpOf(ra) + effExpOf(rb) - 15;
            checkOutput("rand.done", {31'b0, o_done}, 32'd1);
            checkOutput("rand.sign", {31'b0, o_sign}, {31'b0, ra[15] ^ rb[15]});
            checkOutput("rand.exp", {25'b0, o_exp}, {25'b0, 7'(e)});
            checkOutput("rand.mant", {10'b0, o_mant}, 32'(sigOf(ra) * sigOf(rb)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
